// File: rtl/lsq_mem_unit.sv
// Memory stage behind the LSQ: issues the head entry to the D-cache, one access at a time in program order.
// Load data is aligned and extended, then broadcast with the entry's ROB tag. Stores broadcast data 0.
module lsq_mem_unit #(
  parameter int ROB_BITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                head_valid,
  input  logic                head_ready,
  input  logic                head_is_store,
  input  logic [31:0]         head_addr,
  input  logic [3:0]          head_mask,
  input  logic [31:0]         head_wdata,
  input  logic [2:0]          head_funct3,
  input  logic [ROB_BITS-1:0] head_rob_id,
  input  logic [ROB_BITS-1:0] rob_head_id,
  input  logic                flush,
  output logic                lsq_dequeue,
  output logic [31:0]         dmem_addr,
  output logic [3:0]          dmem_rmask,
  output logic [3:0]          dmem_wmask,
  output logic [31:0]         dmem_wdata,
  input  logic [31:0]         dmem_rdata,
  input  logic                dmem_resp,
  output logic                cdb_valid,
  output logic [ROB_BITS-1:0] cdb_rob_id,
  output logic [31:0]         cdb_data,
  output logic                busy
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t              state;
  state_t              state_nxt;
  logic                issue;
  logic                kill;
  logic                kill_hit;
  logic                is_store_q;
  logic [1:0]          off_q;
  logic [2:0]          funct3_q;
  logic [ROB_BITS-1:0] rob_q;
  logic                done_q;

  logic [7:0]          byte_sel;
  logic [15:0]         half_sel;
  logic [31:0]         load_ext;

  logic [31:0]         addr_nxt;
  logic [31:0]         wdata_nxt;
  logic [31:0]         data_nxt;
  logic [3:0]          rmask_nxt;
  logic [3:0]          wmask_nxt;
  logic [ROB_BITS-1:0] rob_nxt;
  logic                done_nxt;
  logic                busy_nxt;

  // Stores wait for the ROB head so they never write memory speculatively.
  assign issue = head_valid & head_ready & ~flush &
                 (~head_is_store | (head_rob_id == rob_head_id));

  // A load flushed in the same cycle as its response is dropped as well.
  assign kill_hit = kill | (flush & ~is_store_q);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (issue) state_nxt = REQ;
      REQ:     state_nxt = WAIT;
      WAIT:    if (dmem_resp) state_nxt = kill_hit ? IDLE : DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      kill       <= 1'b0;
      is_store_q <= 1'b0;
      off_q      <= 2'd0;
      funct3_q   <= 3'd0;
      rob_q      <= '0;
    end else begin
      if (state == IDLE && issue) begin
        is_store_q <= head_is_store;
        off_q      <= head_addr[1:0];
        funct3_q   <= head_funct3;
        rob_q      <= head_rob_id;
      end
      if (state_nxt == IDLE)
        kill <= 1'b0;
      else if ((state == REQ || state == WAIT) && flush && !is_store_q)
        kill <= 1'b1;
    end
  end

  always_comb begin
    byte_sel = 8'h00;
    case (off_q)
      2'd0: byte_sel = dmem_rdata[7:0];
      2'd1: byte_sel = dmem_rdata[15:8];
      2'd2: byte_sel = dmem_rdata[23:16];
      2'd3: byte_sel = dmem_rdata[31:24];
      default: byte_sel = 8'h00;
    endcase
    half_sel = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (funct3_q)
      3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  load_ext = {24'h000000, byte_sel};
      3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
      3'b101:  load_ext = {16'h0000, half_sel};
      default: load_ext = dmem_rdata;
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    addr_nxt  = dmem_addr;
    wdata_nxt = dmem_wdata;
    rmask_nxt = 4'h0;
    wmask_nxt = 4'h0;
    rob_nxt   = cdb_rob_id;
    data_nxt  = cdb_data;
    done_nxt  = 1'b0;
    busy_nxt  = (state_nxt != IDLE);
    if (state == IDLE && issue) begin
      addr_nxt  = {head_addr[31:2], 2'b00};
      wdata_nxt = head_wdata;
      if (head_is_store) wmask_nxt = head_mask;
      else               rmask_nxt = head_mask;
    end
    if (state == WAIT && dmem_resp && !kill_hit) begin
      done_nxt = 1'b1;
      rob_nxt  = rob_q;
      data_nxt = is_store_q ? 32'h0 : load_ext;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dmem_addr  <= 32'h0;
      dmem_wdata <= 32'h0;
      dmem_rmask <= 4'h0;
      dmem_wmask <= 4'h0;
      cdb_rob_id <= '0;
      cdb_data   <= 32'h0;
      done_q     <= 1'b0;
      busy       <= 1'b0;
    end else begin
      dmem_addr  <= addr_nxt;
      dmem_wdata <= wdata_nxt;
      dmem_rmask <= rmask_nxt;
      dmem_wmask <= wmask_nxt;
      cdb_rob_id <= rob_nxt;
      cdb_data   <= data_nxt;
      done_q     <= done_nxt;
      busy       <= busy_nxt;
    end
  end

  // A flush during DONE suppresses the broadcast and the dequeue in that same cycle.
  assign cdb_valid   = done_q & ~flush;
  assign lsq_dequeue = done_q & ~flush;

  assert property (@(posedge clk) disable iff (rst) !((|dmem_rmask) && (|dmem_wmask)));
  assert property (@(posedge clk) disable iff (rst) (state == DONE) |-> done_q);
  assert property (@(posedge clk) disable iff (rst) (is_store_q && state != IDLE) |-> !kill);

endmodule

// File: doc/lsq_mem_unit.md
# lsq_mem_unit

Downstream consumer of the load/store queue. Takes the oldest LSQ entry (slot 0 of the queue output) once its address is resolved and issues it to the data-cache port. For loads it aligns and extends the returned word and broadcasts it on the CDB. It dequeues the entry from the LSQ after the memory response. Memory operations complete one at a time, in program order.

## Interface
- ROB_BITS, 4, width of ROB tags.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- head_valid  in  1  LSQ holds at least one entry (elemcount != 0).
- head_ready  in  1  head entry has a resolved address, mask and wdata.
- head_is_store  in  1  head entry is a store.
- head_addr  in  32  byte address.
- head_mask  in  4  byte mask, already shifted to addr[1:0].
- head_wdata  in  32  store data, already shifted into byte lanes.
- head_funct3  in  3  RV32I load/store funct3.
- head_rob_id  in  ROB_BITS  ROB tag of the head entry.
- rob_head_id  in  ROB_BITS  tag currently at the ROB head.
- flush  in  1  pipeline flush (mispredict).
- lsq_dequeue  out  1  one-cycle pulse that removes the LSQ head.
- dmem_addr  out  32  word-aligned address {addr[31:2],2'b00}.
- dmem_rmask  out  4  read mask; nonzero for exactly one cycle per load.
- dmem_wmask  out  4  write mask; nonzero for exactly one cycle per store.
- dmem_wdata  out  32  write data.
- dmem_rdata  in  32  read data, valid with dmem_resp.
- dmem_resp  in  1  response pulse.
- cdb_valid  out  1  result broadcast, one cycle.
- cdb_rob_id  out  ROB_BITS  tag of the broadcast.
- cdb_data  out  32  load result; 0 for stores.
- busy  out  1  FSM not in IDLE.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE. All outputs are registered.
- IDLE -> REQ when head_valid & head_ready & !flush & (!head_is_store | head_rob_id == rob_head_id).
  - Stores issue only at the ROB head, so they are non-speculative.
  - Loads issue speculatively.
  - On this transition the unit latches addr, mask, wdata, funct3, rob_id and is_store.
- REQ: drives dmem_addr, and drives the mask on dmem_rmask (load) or dmem_wmask (store) for this cycle only. Goes to WAIT unconditionally.
- WAIT: masks are 0; dmem_addr and dmem_wdata hold their values.
  - On dmem_resp, latch dmem_rdata and go to DONE.
  - If the kill flag is set, go to IDLE instead.
- DONE: lsq_dequeue=1 and cdb_valid=1 for one cycle, then go to IDLE.
- Load extraction uses byte offset o = addr[1:0]:
  - LB: sign-extend rdata[8o+7:8o].
  - LBU: zero-extend rdata[8o+7:8o].
  - LH: sign-extend rdata[16o'+15:16o'] with o' = addr[1].
  - LHU: zero-extend the same halfword.
  - LW: pass rdata through.
- Stores broadcast with cdb_data=0 so the ROB can mark them complete.
- Misaligned accesses are not supported; the LSQ producer guarantees alignment.
- Flush handling:
  - Flush in IDLE or DONE: return to or stay in IDLE, with lsq_dequeue=0 and cdb_valid=0 that cycle.
  - Flush in REQ or WAIT: set the kill flag. The request still completes; the response is consumed silently, with no dequeue and no CDB.
  - The kill flag clears on entry to IDLE.
  - A store already in REQ or WAIT is never killed, because it is at the ROB head. Any flush asserted then does not set the kill flag for it.

## Timing
- Reset: state IDLE, kill=0. All outputs are 0: dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata, lsq_dequeue, cdb_valid, cdb_rob_id, cdb_data, busy.
- Issue: the condition holds in cycle t; the mask is visible in cycle t+1.
- Response in cycle r (r >= t+2): cdb_valid and lsq_dequeue in cycle r+1; IDLE in cycle r+2.
- The LSQ updates its tail at the r+1 edge, so the earliest next issue is evaluated in cycle r+2 against the new head. The same entry is never issued twice.
- A dmem_resp outside WAIT is ignored.
- rst mid-operation returns to the reset state on the next edge; an outstanding response is ignored.
- Peak throughput: one operation per 3 + (dcache latency) cycles.

## Test plan
- Load word: head addr=0x1000_0004, LW, mask=4'hF, rob_id=3; dmem_resp 2 cycles after the request with rdata=0xDEADBEEF -> dmem_addr=0x1000_0004 and rmask=F for one cycle, then cdb_valid with rob_id=3 and data=0xDEADBEEF, a single lsq_dequeue pulse, and no reissue.
- LB at addr=0x2003 with rdata=0x80FF_0000 -> cdb_data=0xFFFF_FF80. LBU at the same address -> 0x0000_0080. LHU at 0x2002 -> 0x0000_80FF.
- Store with head_rob_id=5 and rob_head_id=4 -> no wmask while the tags differ. When rob_head_id becomes 5 -> wmask=head_mask and wdata=head_wdata for one cycle; after the response, cdb_valid with data=0 and one dequeue.
- Flush in WAIT of a load, then resp -> no cdb_valid and no lsq_dequeue; busy drops the cycle after resp; the next head is issued normally.
- Back-to-back: two ready loads queued -> the second rmask appears exactly 2 cycles after the first dequeue pulse; a stray dmem_resp while IDLE has no effect.
- rst asserted during WAIT -> all outputs 0 on the next cycle, and a subsequent dmem_resp produces no CDB and no dequeue.
